// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue: default widths, reset PC and the
// all-zero instruction that terminates a program image.
package instr_fetch_queue_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_ZERO   = 32'h0000_0000;
    localparam int          DBG_CNT_W    = 8;

    // ROM words are little-endian: b0 sits at the lowest byte address.
    function automatic logic [31:0] le_word(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Redirect and decode-side handshake of the fetch queue, plus read-only debug state
// (fetch PC, halted flag, queue occupancy) for checkers.
interface instr_fetch_queue_if #(
    parameter int XLEN = instr_fetch_queue_pkg::DEF_XLEN
);
    import instr_fetch_queue_pkg::*;

    logic                 redirect_valid;
    logic [XLEN-1:0]      redirect_pc;
    // Handshake: an entry transfers on a rising edge where out_valid && out_ready and no
    // redirect is present; out_instr/out_pc stay stable while out_valid && !out_ready.
    logic                 out_ready;
    logic                 out_valid;
    logic [XLEN-1:0]      out_instr;
    logic [XLEN-1:0]      out_pc;
    logic                 stop;
    logic [XLEN-1:0]      dbg_fetch_pc;
    logic                 dbg_halted;
    logic [DBG_CNT_W-1:0] dbg_count;

    modport master (
        output redirect_valid, redirect_pc, out_ready,
        input  out_valid, out_instr, out_pc, stop, dbg_fetch_pc, dbg_halted, dbg_count
    );

    modport slave (
        input  redirect_valid, redirect_pc, out_ready,
        output out_valid, out_instr, out_pc, stop, dbg_fetch_pc, dbg_halted, dbg_count
    );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// Multi-push (0..NPUSH entries per cycle), single-pop FIFO with occupancy/free outputs
// and a synchronous flush that outranks push and pop.
module instr_fetch_queue_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8,
    parameter int NPUSH = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_flush,
    input  logic [$clog2(NPUSH+1)-1:0]   i_push_n,
    input  logic [W-1:0]                 i_push_data [NPUSH],
    input  logic                         i_pop,
    output logic [W-1:0]                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [$clog2(DEPTH+1)-1:0]   o_free,
    output logic                         o_empty
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int NW    = $clog2(NPUSH+1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage needs no reset: only entries below r_count are ever presented.
    always_ff @(posedge clk) begin
        if (!i_flush) begin
            for (int k = 0; k < NPUSH; k++) begin
                if (NW'(k) < i_push_n) begin
                    r_mem[r_wr_ptr + PW'(k)] <= i_push_data[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(i_push_n);
            r_rd_ptr <= r_rd_ptr + PW'(i_pop);
            r_count  <= r_count + CNT_W'(i_push_n) - CNT_W'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_free  = CNT_W'(DEPTH) - r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: byte ROM, fetch PC and halt flag feeding a decoupling queue that hands one
// {pc, instr} per cycle to decode; redirect flushes the queue and restarts fetch.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int                     XLEN        = DEF_XLEN,
    parameter int                     MEM_BYTES   = 1024,
    parameter int                     FETCH_WIDTH = 2,
    parameter int                     QUEUE_DEPTH = 8,
    parameter logic [XLEN-1:0]        RESET_PC    = XLEN'(DEF_RESET_PC),
    parameter logic [8*MEM_BYTES-1:0] INIT_IMAGE  = '0
) (
    input  logic               clk,
    input  logic               rstn,
    instr_fetch_queue_if.slave bus
);

    localparam int              AW        = $clog2(MEM_BYTES);
    localparam int              CNT_W     = $clog2(QUEUE_DEPTH+1);
    localparam int              NW        = $clog2(FETCH_WIDTH+1);
    localparam logic [XLEN-1:0] LAST_WORD = XLEN'(MEM_BYTES - 4);

    logic [XLEN-1:0]   r_fetch_pc;
    logic              r_halted;

    logic [7:0]        w_rom       [MEM_BYTES];
    logic [XLEN-1:0]   w_addr      [FETCH_WIDTH];
    logic [AW-1:0]     w_idx       [FETCH_WIDTH];
    logic [XLEN-1:0]   w_word      [FETCH_WIDTH];
    logic [2*XLEN-1:0] w_push_data [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] w_in_rng;
    logic [FETCH_WIDTH-1:0] w_term;
    logic [NW-1:0]     w_n_ok;
    logic [NW-1:0]     w_push_n;
    logic              w_any_term;
    logic              w_redirect;
    logic              w_fire;
    logic              w_pop;
    logic [2*XLEN-1:0] w_head;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_free;
    logic              w_empty;

    // ROM image byte b lives at INIT_IMAGE[8b+7:8b]; contents are fixed at elaboration.
    for (genvar b = 0; b < MEM_BYTES; b++) begin : g_rom
        assign w_rom[b] = INIT_IMAGE[8*b +: 8];
    end

    // A word is terminal when it is zero or would read past the last ROM byte.
    always_comb begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            w_addr[k]      = r_fetch_pc + XLEN'(4 * k);
            w_in_rng[k]    = (w_addr[k] <= LAST_WORD);
            w_idx[k]       = w_addr[k][AW-1:0];
            w_word[k]      = w_in_rng[k]
                           ? XLEN'(le_word(w_rom[w_idx[k]],           w_rom[w_idx[k] + AW'(1)],
                                           w_rom[w_idx[k] + AW'(2)],  w_rom[w_idx[k] + AW'(3)]))
                           : XLEN'(INSTR_ZERO);
            w_term[k]      = !w_in_rng[k] || (w_word[k] == XLEN'(INSTR_ZERO));
            w_push_data[k] = {w_addr[k], w_word[k]};
        end
    end

    always_comb begin
        w_n_ok = NW'(FETCH_WIDTH);
        for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
            if (w_term[k]) begin
                w_n_ok = NW'(k);
            end
        end
    end

    assign w_any_term = |w_term;
    assign w_redirect = bus.redirect_valid;
    // Free slots come from the start-of-cycle count, so a same-cycle pop never enables a push.
    assign w_fire     = !r_halted && !w_redirect && (w_free >= CNT_W'(FETCH_WIDTH));
    assign w_push_n   = w_fire ? w_n_ok : '0;
    assign w_pop      = !w_empty && bus.out_ready && !w_redirect;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fetch_pc <= RESET_PC;
            r_halted   <= 1'b0;
        end else if (w_redirect) begin
            r_fetch_pc <= bus.redirect_pc & ~XLEN'(3);
            r_halted   <= 1'b0;
        end else if (w_fire) begin
            if (w_any_term) begin
                r_halted <= 1'b1;
            end else begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4 * FETCH_WIDTH);
            end
        end
    end

    instr_fetch_queue_fifo #(
        .W     (2 * XLEN),
        .DEPTH (QUEUE_DEPTH),
        .NPUSH (FETCH_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .i_flush     (w_redirect),
        .i_push_n    (w_push_n),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_free      (w_free),
        .o_empty     (w_empty)
    );

    assign bus.out_valid    = !w_empty;
    assign bus.out_pc       = w_empty ? '0 : w_head[2*XLEN-1:XLEN];
    assign bus.out_instr    = w_empty ? '0 : w_head[XLEN-1:0];
    assign bus.stop         = r_halted && w_empty;
    assign bus.dbg_fetch_pc = r_fetch_pc;
    assign bus.dbg_halted   = r_halted;
    assign bus.dbg_count    = DBG_CNT_W'(w_count);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed sequences push expected {pc, instr} pairs, a
// negedge monitor pops and compares every delivery.
module tb_instr_fetch_queue;

    localparam int MEM = 1024;

    // Image: 0x13, 0x93, 0x113, 0 at 0x0..0xC, then nonzero {addr[15:0], 16'h0013} to 0x3FC.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0000_0093;
        if (a == 32'h8) return 32'h0000_0113;
        if (a == 32'hC) return 32'h0000_0000;
        return {a[15:0], 16'h0013};
    endfunction

    function automatic logic [8*MEM-1:0] build_image();
        logic [8*MEM-1:0] img;
        img = '0;
        for (int a = 0; a < MEM; a += 4) begin
            img[8*a +: 32] = word_at(32'(a));
        end
        return img;
    endfunction

    localparam logic [8*MEM-1:0] IMAGE = build_image();

    logic        clk;
    logic        rstn;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    int          n_tests;
    int          n_fail;

    instr_fetch_queue_if #(.XLEN(32)) bus ();

    instr_fetch_queue #(
        .XLEN        (32),
        .MEM_BYTES   (MEM),
        .FETCH_WIDTH (2),
        .QUEUE_DEPTH (8),
        .RESET_PC    (32'h0),
        .INIT_IMAGE  (IMAGE)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        step(1);
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
    endtask

    task automatic expect_range(input logic [31:0] from, input logic [31:0] to);
        for (logic [31:0] a = from; a <= to; a += 4) begin
            exp_q.push_back({a, word_at(a)});
        end
    endtask

    task automatic wait_stop(input string name, input int budget);
        int n;
        n = 0;
        while (bus.stop !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        check(name, 32'(bus.stop), 32'd1);
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        step(2);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_pc",    bus.out_pc,         32'd0);
        check("rst_instr", bus.out_instr,      32'd0);
        check("rst_stop",  32'(bus.stop),      32'd0);
        check("rst_fpc",   bus.dbg_fetch_pc,   32'd0);
        rstn = 1'b1;
    endtask

    // scoreboard monitor: a delivery is valid && ready with no redirect in the same cycle
    always @(negedge clk) begin
        if (rstn && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL deliver: unexpected pc=%h instr=%h", bus.out_pc, bus.out_instr);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.out_pc, bus.out_instr} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL deliver: got pc=%h instr=%h expected pc=%h instr=%h",
                             bus.out_pc, bus.out_instr, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    initial begin
        n_tests            = 0;
        n_fail             = 0;
        rstn               = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;

        // Backpressure: three entries held, head stable, no stop until drained.
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_instr", bus.out_instr,      32'h0000_0013);
            check("hold_pc",    bus.out_pc,         32'h0);
            check("hold_stop",  32'(bus.stop),      32'd0);
        end
        check("hold_count",  32'(bus.dbg_count),  32'd3);
        check("hold_halted", 32'(bus.dbg_halted), 32'd1);
        check("hold_fpc",    bus.dbg_fetch_pc,    32'h8);
        expect_range(32'h0, 32'h8);
        bus.out_ready = 1'b1;
        step(1);
        check("drain_stop1", 32'(bus.stop), 32'd0);
        step(1);
        check("drain_stop2", 32'(bus.stop), 32'd0);
        step(1);
        check("drain_stop3",  32'(bus.stop),      32'd1);
        check("drain_valid",  32'(bus.out_valid), 32'd0);
        check("drain_pc0",    bus.out_pc,         32'd0);
        check("drain_instr0", bus.out_instr,      32'd0);
        step(5);
        check("stop_sticky", 32'(bus.stop),      32'd1);
        check("stop_count",  32'(bus.dbg_count), 32'd0);

        // Streaming with out_ready=1: PCs 0, 4, 8 on consecutive cycles.
        expect_range(32'h0, 32'h8);
        apply_reset();
        step(1);
        check("stream_pc0", bus.out_pc, 32'h0);
        step(1);
        check("stream_pc4", bus.out_pc, 32'h4);
        step(1);
        check("stream_pc8", bus.out_pc, 32'h8);
        step(1);
        check("stream_valid", 32'(bus.out_valid), 32'd0);
        check("stream_stop",  32'(bus.stop),      32'd1);
        check("stream_drain", 32'(exp_q.size()),  32'd0);

        // Redirect out of stop, fill to depth, then stream to the ROM boundary.
        bus.out_ready = 1'b0;
        do_redirect(32'h10);
        check("redir_stop", 32'(bus.stop),   32'd0);
        check("redir_fpc",  bus.dbg_fetch_pc, 32'h10);
        step(10);
        check("full_count", 32'(bus.dbg_count), 32'd8);
        check("full_fpc",   bus.dbg_fetch_pc,    32'h30);
        check("full_pc",    bus.out_pc,          32'h10);
        check("full_instr", bus.out_instr,       32'h0010_0013);
        expect_range(32'h10, 32'h3FC);
        bus.out_ready = 1'b1;
        wait_stop("bound_stop", 600);
        check("bound_fpc", bus.dbg_fetch_pc, 32'h400);

        // Redirect to 0x41 with five entries queued and out_ready=1.
        expect_range(32'h20, 32'h28);
        do_redirect(32'h20);
        step(4);
        check("pre_redir_count", 32'(bus.dbg_count), 32'd5);
        check("pre_redir_pc",    bus.out_pc,          32'h2C);
        do_redirect(32'h41);
        check("post_redir_valid", 32'(bus.out_valid), 32'd0);
        expect_range(32'h40, 32'h3FC);
        step(1);
        check("post_redir_pc",    bus.out_pc,    32'h40);
        check("post_redir_instr", bus.out_instr, 32'h0040_0013);
        wait_stop("redir_run_stop", 600);

        // Asynchronous reset with six entries queued.
        bus.out_ready = 1'b0;
        do_redirect(32'h10);
        step(3);
        check("mid_count", 32'(bus.dbg_count), 32'd6);
        #2;
        rstn = 1'b0;
        #1;
        check("async_valid", 32'(bus.out_valid), 32'd0);
        check("async_pc",    bus.out_pc,         32'd0);
        check("async_instr", bus.out_instr,      32'd0);
        check("async_stop",  32'(bus.stop),      32'd0);
        check("async_count", 32'(bus.dbg_count), 32'd0);
        step(2);
        rstn          = 1'b1;
        bus.out_ready = 1'b1;
        expect_range(32'h0, 32'h8);
        step(1);
        check("restart_pc", bus.out_pc, 32'h0);
        wait_stop("restart_stop", 50);
        check("restart_fpc", bus.dbg_fetch_pc, 32'h8);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
